// File: rtl/onchip_ram_pkg.sv
// Shared types and helpers for the pipelined on-chip RAM slave.
package onchip_ram_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } ram_state_e;

  function automatic int NUM_BYTES(input int data_width);
    return data_width / BYTE_W;
  endfunction

endpackage

// File: rtl/onchip_ram_core.sv
// Inferred single-port RAM with per-byte write enables and a registered read port.
module onchip_ram_core
  import onchip_ram_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 14
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             en,
  input  logic [ADDR_WIDTH-1:0]            addr,
  input  logic [NUM_BYTES(DATA_WIDTH)-1:0] we,
  input  logic [DATA_WIDTH-1:0]            wdata,
  input  logic                             re,
  output logic [DATA_WIDTH-1:0]            rdata
);

  localparam int NB = NUM_BYTES(DATA_WIDTH);

  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

  always_ff @(posedge clk) begin
    if (en) begin
      for (int i = 0; i < NB; i++) begin
        if (we[i]) begin
          mem[addr][i*BYTE_W +: BYTE_W] <= wdata[i*BYTE_W +: BYTE_W];
        end
      end
    end
  end

  // The read register holds its value while disabled so a stalled result stays on the bus.
  always_ff @(posedge clk) begin
    if (reset) begin
      rdata <= '0;
    end else if (en && re) begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/onchip_ram_pipelined.sv
// Avalon-MM on-chip RAM slave: post-reset zero-clear FSM, request acceptance,
// and a read pipeline of one or two stages with readdatavalid.
module onchip_ram_pipelined
  import onchip_ram_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 14,
  parameter int READ_LATENCY = 1,
  parameter int INIT_CLEAR   = 1
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [ADDR_WIDTH-1:0]            address,
  input  logic [NUM_BYTES(DATA_WIDTH)-1:0] byteenable,
  input  logic                             chipselect,
  input  logic                             read,
  input  logic                             write,
  input  logic [DATA_WIDTH-1:0]            writedata,
  input  logic                             clken,
  input  logic                             reset_req,
  output logic [DATA_WIDTH-1:0]            readdata,
  output logic                             readdatavalid,
  output logic                             waitrequest,
  output logic                             init_done
);

  localparam int NB = NUM_BYTES(DATA_WIDTH);

  ram_state_e            state, state_next;
  logic [ADDR_WIDTH-1:0] clear_cnt, clear_cnt_next;
  logic                  en;
  logic                  accept;
  logic                  wr_acc;
  logic                  rd_acc;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [NB-1:0]         mem_we;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic                  mem_re;
  logic [DATA_WIDTH-1:0] core_rdata;
  logic                  stage1_valid;

  assign en          = clken & ~reset_req;
  assign waitrequest = (state == CLEAR) | ~en;
  assign accept      = chipselect & (read | write) & ~waitrequest;
  assign wr_acc      = accept & write;
  // A combined read+write is treated as a write only; the read is dropped.
  assign rd_acc      = accept & read & ~write;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= (INIT_CLEAR != 0) ? CLEAR : READY;
      clear_cnt <= '0;
    end else if (en) begin
      state     <= state_next;
      clear_cnt <= clear_cnt_next;
    end
  end

  always_comb begin
    state_next     = state;
    clear_cnt_next = clear_cnt;
    mem_addr       = address;
    mem_we         = '0;
    mem_wdata      = writedata;
    mem_re         = 1'b0;
    unique case (state)
      CLEAR: begin
        mem_addr       = clear_cnt;
        mem_we         = '1;
        mem_wdata      = '0;
        clear_cnt_next = clear_cnt + 1'b1;
        if (clear_cnt == '1) begin
          state_next = READY;
        end
      end
      READY: begin
        if (wr_acc) begin
          mem_we = byteenable;
        end
        mem_re = rd_acc;
      end
    endcase
    if (reset) begin
      mem_we = '0;
    end
  end

  onchip_ram_core #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_core (
    .clk   (clk),
    .reset (reset),
    .en    (en),
    .addr  (mem_addr),
    .we    (mem_we),
    .wdata (mem_wdata),
    .re    (mem_re),
    .rdata (core_rdata)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      stage1_valid <= 1'b0;
    end else if (en) begin
      stage1_valid <= rd_acc;
    end
  end

  // Valid is masked while disabled; the held stage re-presents once enable returns.
  generate
    if (READ_LATENCY == 2) begin : g_lat2
      logic                  stage2_valid;
      logic [DATA_WIDTH-1:0] stage2_data;

      always_ff @(posedge clk) begin
        if (reset) begin
          stage2_valid <= 1'b0;
          stage2_data  <= '0;
        end else if (en) begin
          stage2_valid <= stage1_valid;
          stage2_data  <= core_rdata;
        end
      end

      assign readdatavalid = stage2_valid & en;
      assign readdata      = stage2_data;
    end else begin : g_lat1
      assign readdatavalid = stage1_valid & en;
      assign readdata      = core_rdata;
    end
  endgenerate

  generate
    if (INIT_CLEAR != 0) begin : g_init_clear
      assign init_done = (state == READY);
    end else begin : g_no_clear
      assign init_done = 1'b1;
    end
  endgenerate

endmodule

// File: tb/tb_onchip_ram_pipelined.sv
// Bench for onchip_ram_pipelined: latency-1 and latency-2 instances share one stimulus
// stream and are checked against a queue/array reference model and fixed vector tables.
module tb_onchip_ram_pipelined;

  localparam int DW    = 32;
  localparam int AW    = 4;
  localparam int DEPTH = 1 << AW;
  localparam int NB    = DW / 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset      = 1'b1;
  logic          chipselect = 1'b0;
  logic          read       = 1'b0;
  logic          write      = 1'b0;
  logic          clken      = 1'b1;
  logic          reset_req  = 1'b0;
  logic [AW-1:0] address    = '0;
  logic [NB-1:0] byteenable = '0;
  logic [DW-1:0] writedata  = '0;

  logic [DW-1:0] rdata1, rdata2, rdata0;
  logic          rdv1, rdv2, rdv0;
  logic          wr1, wr2, wr0;
  logic          done1, done2, done0;

  onchip_ram_pipelined #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .READ_LATENCY(1), .INIT_CLEAR(1)) u_lat1 (
    .clk(clk), .reset(reset), .address(address), .byteenable(byteenable),
    .chipselect(chipselect), .read(read), .write(write), .writedata(writedata),
    .clken(clken), .reset_req(reset_req), .readdata(rdata1), .readdatavalid(rdv1),
    .waitrequest(wr1), .init_done(done1)
  );

  onchip_ram_pipelined #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .READ_LATENCY(2), .INIT_CLEAR(1)) u_lat2 (
    .clk(clk), .reset(reset), .address(address), .byteenable(byteenable),
    .chipselect(chipselect), .read(read), .write(write), .writedata(writedata),
    .clken(clken), .reset_req(reset_req), .readdata(rdata2), .readdatavalid(rdv2),
    .waitrequest(wr2), .init_done(done2)
  );

  onchip_ram_pipelined #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .READ_LATENCY(1), .INIT_CLEAR(0)) u_noclr (
    .clk(clk), .reset(reset), .address(address), .byteenable(byteenable),
    .chipselect(chipselect), .read(read), .write(write), .writedata(writedata),
    .clken(clken), .reset_req(reset_req), .readdata(rdata0), .readdatavalid(rdv0),
    .waitrequest(wr0), .init_done(done0)
  );

  typedef struct {
    logic [DW-1:0] data;
    int            stage;
  } pend_t;

  typedef struct {
    logic          cs, rd, wr;
    logic [AW-1:0] addr;
    logic [NB-1:0] be;
    logic [DW-1:0] wd;
    logic          has_result;
    logic [DW-1:0] exp;
  } vec_t;

  pend_t         pend1[$];
  pend_t         pend2[$];
  logic [DW-1:0] mem_model [DEPTH];
  int            clear_left  = 0;
  bit            model_valid = 1'b0;
  int            n_cmp       = 0;
  int            n_fail      = 0;

  logic          s_wr1, s_done1, s_rdv1, s_rdv2;
  logic [DW-1:0] s_rd1, s_rd2;
  logic [DW-1:0] got1[$];
  logic [DW-1:0] got2[$];

  function automatic vec_t mk(input logic cs, input logic rd, input logic wr, input logic [AW-1:0] a,
                              input logic [NB-1:0] be, input logic [DW-1:0] wd,
                              input logic has, input logic [DW-1:0] exp);
    vec_t v;
    v.cs = cs; v.rd = rd; v.wr = wr; v.addr = a; v.be = be; v.wd = wd;
    v.has_result = has; v.exp = exp;
    return v;
  endfunction

  task automatic check_bit(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %b, expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_output(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_count(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // One bus cycle: drive, compare against the model, take the edge, advance the model.
  task automatic apply_stimulus(input logic rst, input logic cs, input logic rd, input logic wr,
                                input logic ce, input logic rq, input logic [AW-1:0] a,
                                input logic [NB-1:0] be, input logic [DW-1:0] wd);
    logic  en, clearing, ev1, ev2;
    pend_t p;
    reset = rst; chipselect = cs; read = rd; write = wr;
    clken = ce; reset_req = rq; address = a; byteenable = be; writedata = wd;
    #1;
    en       = ce & ~rq;
    clearing = (clear_left > 0);
    s_wr1 = wr1; s_done1 = done1; s_rdv1 = rdv1; s_rdv2 = rdv2; s_rd1 = rdata1; s_rd2 = rdata2;
    if (rdv1 === 1'b1) got1.push_back(rdata1);
    if (rdv2 === 1'b1) got2.push_back(rdata2);
    if (model_valid) begin
      ev1 = en && pend1.size() > 0 && pend1[0].stage == 1;
      ev2 = en && pend2.size() > 0 && pend2[0].stage == 2;
      check_bit("waitrequest_l1", wr1, clearing | ~en);
      check_bit("waitrequest_l2", wr2, clearing | ~en);
      check_bit("init_done_l1", done1, ~clearing);
      check_bit("init_done_l2", done2, ~clearing);
      check_bit("waitrequest_noclr", wr0, ~en);
      check_bit("init_done_noclr", done0, 1'b1);
      check_bit("readdatavalid_l1", rdv1, ev1);
      check_bit("readdatavalid_l2", rdv2, ev2);
      if (ev1) check_output("readdata_l1", rdata1, pend1[0].data);
      if (ev2) check_output("readdata_l2", rdata2, pend2[0].data);
    end
    @(posedge clk);
    if (rst) begin
      pend1.delete();
      pend2.delete();
      clear_left  = DEPTH;
      model_valid = 1'b1;
    end else if (en) begin
      if (pend1.size() > 0 && pend1[0].stage == 1) pend1.delete(0);
      if (pend2.size() > 0 && pend2[0].stage == 2) pend2.delete(0);
      foreach (pend2[i]) pend2[i].stage++;
      if (clearing) begin
        mem_model[DEPTH - clear_left] = '0;
        clear_left--;
      end else if (cs && wr) begin
        for (int b = 0; b < NB; b++) begin
          if (be[b]) mem_model[a][b*8 +: 8] = wd[b*8 +: 8];
        end
      end else if (cs && rd) begin
        p.data  = mem_model[a];
        p.stage = 1;
        pend1.push_back(p);
        pend2.push_back(p);
      end
    end
    #1;
  endtask

  task automatic idle();
    apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, '0, '0, '0);
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [NB-1:0] be, input logic [DW-1:0] d);
    apply_stimulus(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, a, be, d);
  endtask

  task automatic do_read(input logic [AW-1:0] a);
    apply_stimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, a, '0, '0);
  endtask

  // Counts refused cycles until init_done; the 40-cycle bound doubles as a timeout.
  task automatic wait_clear(output int n_wait, output int n_rdv);
    n_wait = 0;
    n_rdv  = 0;
    for (int i = 0; i < 40; i++) begin
      idle();
      if (s_rdv1 === 1'b1 || s_rdv2 === 1'b1) n_rdv++;
      if (s_done1 === 1'b1) break;
      if (s_wr1 === 1'b1) n_wait++;
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t          vecs[16];
    logic [DW-1:0] exp_q[$];
    logic          rv1[8], rv2[8];
    logic [DW-1:0] rd1a[8], rd2a[8];
    int            n_wait, n_rdv;

    foreach (mem_model[i]) mem_model[i] = '0;

    // Reset state
    apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, '0, '0, '0);
    apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, '0, '0, '0);
    check_output("reset_readdata_l1", s_rd1, '0);
    check_output("reset_readdata_l2", s_rd2, '0);
    check_bit("reset_waitrequest", s_wr1, 1'b1);
    check_bit("reset_init_done", s_done1, 1'b0);

    // Clear sequence length
    wait_clear(n_wait, n_rdv);
    check_count("clear_cycles", n_wait, 16);

    // Fill with a pattern, reset mid-clear at counter 9, then verify a full re-clear
    for (int a = 0; a < DEPTH; a++) do_write(AW'(a), 4'hF, 32'hDEADBEEF);
    apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, '0, '0, '0);
    for (int k = 0; k < 9; k++) idle();
    apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0);
    apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, '0, '0, '0);
    wait_clear(n_wait, n_rdv);
    check_count("clear_cycles_after_midclear_reset", n_wait, 16);
    got1.delete();
    got2.delete();
    for (int a = 0; a < DEPTH; a++) do_read(AW'(a));
    for (int k = 0; k < 3; k++) idle();
    check_count("clear_read_count_l1", got1.size(), DEPTH);
    check_count("clear_read_count_l2", got2.size(), DEPTH);
    foreach (got1[i]) check_output("cleared_word_l1", got1[i], 32'h0);
    foreach (got2[i]) check_output("cleared_word_l2", got2[i], 32'h0);

    // Table-driven transactions, one per cycle
    vecs[0]  = mk(1, 0, 1, 4'd5,  4'hF, 32'h11223344, 0, 32'h0);
    vecs[1]  = mk(1, 0, 1, 4'd5,  4'h5, 32'hAABBCCDD, 0, 32'h0);
    vecs[2]  = mk(1, 1, 0, 4'd5,  4'h0, 32'h0,        1, 32'h11BB33DD);
    vecs[3]  = mk(1, 1, 1, 4'd7,  4'hF, 32'h00000055, 0, 32'h0);
    vecs[4]  = mk(1, 1, 0, 4'd7,  4'h0, 32'h0,        1, 32'h00000055);
    vecs[5]  = mk(1, 0, 1, 4'd9,  4'h0, 32'hFFFFFFFF, 0, 32'h0);
    vecs[6]  = mk(1, 1, 0, 4'd9,  4'h0, 32'h0,        1, 32'h00000000);
    vecs[7]  = mk(0, 0, 1, 4'd10, 4'hF, 32'h12345678, 0, 32'h0);
    vecs[8]  = mk(0, 1, 0, 4'd10, 4'h0, 32'h0,        0, 32'h0);
    vecs[9]  = mk(1, 1, 0, 4'd10, 4'h0, 32'h0,        1, 32'h00000000);
    vecs[10] = mk(1, 0, 1, 4'd12, 4'hF, 32'hCAFEF00D, 0, 32'h0);
    vecs[11] = mk(1, 1, 0, 4'd12, 4'h0, 32'h0,        1, 32'hCAFEF00D);
    vecs[12] = mk(1, 0, 1, 4'd0,  4'hF, 32'h000000A0, 0, 32'h0);
    vecs[13] = mk(1, 0, 1, 4'd1,  4'hF, 32'h000000A1, 0, 32'h0);
    vecs[14] = mk(1, 0, 1, 4'd2,  4'hF, 32'h000000A2, 0, 32'h0);
    vecs[15] = mk(1, 0, 1, 4'd3,  4'hF, 32'h000000A3, 0, 32'h0);
    got1.delete();
    got2.delete();
    foreach (vecs[i]) begin
      apply_stimulus(1'b0, vecs[i].cs, vecs[i].rd, vecs[i].wr, 1'b1, 1'b0,
                     vecs[i].addr, vecs[i].be, vecs[i].wd);
      if (vecs[i].has_result) exp_q.push_back(vecs[i].exp);
    end
    for (int k = 0; k < 3; k++) idle();
    check_count("table_result_count_l1", got1.size(), exp_q.size());
    check_count("table_result_count_l2", got2.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got1.size(); i++) check_output("table_data_l1", got1[i], exp_q[i]);
    for (int i = 0; i < exp_q.size() && i < got2.size(); i++) check_output("table_data_l2", got2[i], exp_q[i]);

    // Back-to-back reads of 0..3
    for (int c = 0; c < 8; c++) begin
      if (c < 4) do_read(AW'(c));
      else idle();
      rv1[c] = s_rdv1; rv2[c] = s_rdv2; rd1a[c] = s_rd1; rd2a[c] = s_rd2;
    end
    for (int c = 0; c < 8; c++) begin
      check_bit("burst_valid_l1", rv1[c], c >= 1 && c <= 4);
      check_bit("burst_valid_l2", rv2[c], c >= 2 && c <= 5);
      if (c >= 1 && c <= 4) check_output("burst_data_l1", rd1a[c], DW'(32'hA0 + c - 1));
      if (c >= 2 && c <= 5) check_output("burst_data_l2", rd2a[c], DW'(32'hA0 + c - 2));
    end

    // Stall after an accepted read: clken low, then reset_req high
    for (int mode = 0; mode < 2; mode++) begin
      do_read(4'd2);
      for (int k = 0; k < 3; k++) begin
        apply_stimulus(1'b0, 1'b1, 1'b1, 1'b0, mode == 1, mode == 1, 4'd3, '0, '0);
        check_bit("stall_waitrequest", s_wr1, 1'b1);
        check_bit("stall_readdatavalid", s_rdv1, 1'b0);
      end
      idle();
      check_bit("resume_readdatavalid", s_rdv1, 1'b1);
      check_output("resume_readdata", s_rd1, 32'h000000A2);
      idle();
      check_bit("resume_single_pulse", s_rdv1, 1'b0);
      idle();
    end

    // Reset with a read in flight
    do_read(4'd3);
    apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0);
    n_rdv = (s_rdv1 === 1'b1 || s_rdv2 === 1'b1) ? 1 : 0;
    check_count("flush_rdv_in_reset_cycle", n_rdv, 0);
    wait_clear(n_wait, n_rdv);
    check_count("clear_cycles_after_read_flush", n_wait, 16);
    check_count("flushed_read_rdv", n_rdv, 0);

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      apply_stimulus($urandom_range(0, 199) == 0, $urandom_range(0, 3) != 0,
                     1'($urandom_range(0, 1)), $urandom_range(0, 2) == 0,
                     $urandom_range(0, 7) != 0, $urandom_range(0, 9) == 0,
                     AW'($urandom), NB'($urandom), $urandom);
    end
    for (int k = 0; k < 4; k++) idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
